stack_pointer_ctrl: RTL and testbench
=====================================

Name: stack_pointer_ctrl

Overview:
- Parametrised next-generation stack pointer for the RAT MCU.
- Generalised in width, reset value and maximum depth.
- Adds full/empty flags, sticky overflow/underflow errors, and a multi-cycle interrupt-frame push sequencer that emits one scratch-RAM write address per cycle.
- Sits between the control unit and the scratch-RAM address mux.

Parameters:
- WIDTH, 8, pointer and DATA width in bits.
- RESET_VAL, 0, pointer value after reset; this is the empty-stack value.
- DEPTH_MAX, 255, maximum entries; must be ≤ 2^WIDTH-1.
- FRAME_WORDS, 2, words pushed per frame sequence; range 1..DEPTH_MAX.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- DATA  in  WIDTH  load value.
- LD  in  1  load DATA into pointer.
- INCR  in  1  pop: pointer +1.
- DECR  in  1  push: pointer -1.
- FRAME_START  in  1  request frame push.
- ERR_CLR  in  1  clear sticky OVF/UNF.
- OUT  out  WIDTH  current pointer.
- EMPTY  out  1  depth == 0.
- FULL  out  1  depth == DEPTH_MAX.
- OVF  out  1  sticky overflow.
- UNF  out  1  sticky underflow.
- BUSY  out  1  frame sequencer active.
- FRAME_VALID  out  1  FRAME_ADDR valid this cycle.
- FRAME_ADDR  out  WIDTH  write address, OUT-1 modulo 2^WIDTH.
- FRAME_IDX  out  $clog2(FRAME_WORDS+1)  word index, 0 first.
- FRAME_DONE  out  1  one-cycle pulse after the last frame word.

Behaviour:
- Depth definition:
  - depth = (RESET_VAL - OUT) mod 2^WIDTH.
  - EMPTY and FULL are combinational from depth.
- Reset (RST=1 at edge):
  - OUT=RESET_VAL; state=IDLE.
  - OVF=UNF=0; FRAME_IDX=0; FRAME_DONE=0.
  - RST overrides everything, including an active frame, which is abandoned mid-sequence.
- IDLE precedence, evaluated per edge: FRAME_START > LD > INCR > DECR.
  - LD: OUT<=DATA unconditionally; flags are not touched.
  - INCR: if EMPTY, OUT is held and UNF<=1; else OUT<=OUT+1.
  - DECR: if FULL, OUT is held and OVF<=1; else OUT<=OUT-1.
  - Arithmetic wraps modulo 2^WIDTH. The guard above prevents wrap past the depth limits, but not past a LD value.
- FRAME_START in IDLE:
  - If depth+FRAME_WORDS > DEPTH_MAX: OVF<=1, stay IDLE, no FRAME_DONE.
  - Else: go to BURST, FRAME_IDX<=0.
- BURST state:
  - BUSY=1 and FRAME_VALID=1 combinationally.
  - FRAME_ADDR=OUT-1 combinationally.
  - Each edge: OUT<=OUT-1 and FRAME_IDX<=FRAME_IDX+1.
  - When FRAME_IDX==FRAME_WORDS-1 at the edge: go to IDLE and FRAME_DONE<=1 for exactly one cycle.
  - Total: FRAME_WORDS valid cycles. Final OUT = start value - FRAME_WORDS.
- During BURST: LD, INCR, DECR and FRAME_START are ignored and not queued.
- FRAME_DONE cycle: the block is IDLE and accepts new commands in that same cycle.
- ERR_CLR:
  - Clears OVF and UNF at the edge.
  - If an error-setting event occurs in the same cycle, the set wins.
- Outside BURST: FRAME_VALID=0, FRAME_ADDR still shows OUT-1, FRAME_IDX=0.

Optional Feature:
- Macro: STACK_SHADOW_EN.
- When defined:
  - Adds inputs SAVE (1) and RESTORE (1) and output SHADOW (WIDTH).
  - SAVE in IDLE: SHADOW<=OUT.
  - RESTORE in IDLE: OUT<=SHADOW, at precedence just below FRAME_START and above LD.
  - SAVE and RESTORE together: both occur, swapping OUT and SHADOW.
  - Reset value of SHADOW is RESET_VAL. Both inputs are ignored in BURST.
- When undefined: the ports and register are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then INCR=1 (WIDTH=8, RESET_VAL=0) -> OUT=0x00, EMPTY=1, UNF=1; ERR_CLR -> UNF=0.
- Three DECR from reset -> OUT=0xFD, depth 3, EMPTY=0; then INCR with DECR held high -> OUT=0xFE (INCR wins).
- LD DATA=0x01 (depth 255 with DEPTH_MAX=255) -> FULL=1; DECR -> OUT stays 0x01, OVF=1.
- OUT=0x20, FRAME_START with FRAME_WORDS=2 -> FRAME_ADDR 0x1F then 0x1E on FRAME_IDX 0,1; OUT=0x1E; FRAME_DONE next cycle; a LD issued mid-burst is ignored.
- FRAME_START at depth 254 (FRAME_WORDS=2) -> no BUSY, OVF=1, OUT unchanged; RST during BURST at FRAME_IDX=1 -> OUT=0x00, BUSY=0, no FRAME_DONE.
- With STACK_SHADOW_EN: OUT=0x40, SAVE; LD 0x10; RESTORE -> OUT=0x40, SHADOW=0x40; SAVE+RESTORE at OUT=0x30, SHADOW=0x40 -> OUT=0x40, SHADOW=0x30.

Source files
------------

// File: rtl/stack_pointer_ctrl.sv
// Parametrised stack pointer with depth flags, sticky errors and an interrupt-frame push sequencer.
// Optional shadow register (SAVE/RESTORE/SHADOW) is built when STACK_SHADOW_EN is defined.
module stack_pointer_ctrl #(
  parameter int WIDTH       = 8,
  parameter int RESET_VAL   = 0,
  parameter int DEPTH_MAX   = 255,
  parameter int FRAME_WORDS = 2
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [WIDTH-1:0]                   DATA,
  input  logic                               LD,
  input  logic                               INCR,
  input  logic                               DECR,
  input  logic                               FRAME_START,
  input  logic                               ERR_CLR,
`ifdef STACK_SHADOW_EN
  input  logic                               SAVE,
  input  logic                               RESTORE,
  output logic [WIDTH-1:0]                   SHADOW,
`endif
  output logic [WIDTH-1:0]                   OUT,
  output logic                               EMPTY,
  output logic                               FULL,
  output logic                               OVF,
  output logic                               UNF,
  output logic                               BUSY,
  output logic                               FRAME_VALID,
  output logic [WIDTH-1:0]                   FRAME_ADDR,
  output logic [$clog2(FRAME_WORDS+1)-1:0]   FRAME_IDX,
  output logic                               FRAME_DONE
);

  localparam int IDX_W = $clog2(FRAME_WORDS + 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_PTR   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] DMAX      = WIDTH'(DEPTH_MAX);
  localparam logic [WIDTH:0]   DMAX_WIDE = (WIDTH+1)'(DEPTH_MAX);
  localparam logic [WIDTH:0]   FW_WIDE   = (WIDTH+1)'(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_WORDS - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   out_q, out_n;
  logic               ovf_q, ovf_n;
  logic               unf_q, unf_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               done_q, done_n;
  logic [WIDTH-1:0]   depth;
  logic               frame_fits;
`ifdef STACK_SHADOW_EN
  logic [WIDTH-1:0]   shadow_q, shadow_n;
`endif

  // Depth counts downward-growing entries below the empty-stack value.
  assign depth      = RST_PTR - out_q;
  assign frame_fits = ({1'b0, depth} + FW_WIDE) <= DMAX_WIDE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      out_q   <= RST_PTR;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef STACK_SHADOW_EN
      shadow_q <= RST_PTR;
`endif
    end else begin
      state_q <= state_n;
      out_q   <= out_n;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
      idx_q   <= idx_n;
      done_q  <= done_n;
`ifdef STACK_SHADOW_EN
      shadow_q <= shadow_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    out_n   = out_q;
    ovf_n   = ovf_q;
    unf_n   = unf_q;
    idx_n   = '0;
    done_n  = 1'b0;
`ifdef STACK_SHADOW_EN
    shadow_n = shadow_q;
`endif
    // Clear first so a same-cycle error event below takes priority.
    if (ERR_CLR) begin
      ovf_n = 1'b0;
      unf_n = 1'b0;
    end
    case (state_q)
      IDLE: begin
`ifdef STACK_SHADOW_EN
        if (SAVE) shadow_n = out_q;
`endif
        if (FRAME_START) begin
          if (frame_fits) state_n = BURST;
          else            ovf_n   = 1'b1;
        end
`ifdef STACK_SHADOW_EN
        else if (RESTORE) begin
          out_n = shadow_q;
        end
`endif
        else if (LD) begin
          out_n = DATA;
        end else if (INCR) begin
          if (EMPTY) unf_n = 1'b1;
          else       out_n = out_q + ONE;
        end else if (DECR) begin
          if (FULL) ovf_n = 1'b1;
          else      out_n = out_q - ONE;
        end
      end
      BURST: begin
        out_n = out_q - ONE;
        if (idx_q == LAST_IDX) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          idx_n = idx_q + IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign OUT         = out_q;
  assign EMPTY       = (depth == '0);
  assign FULL        = (depth == DMAX);
  assign OVF         = ovf_q;
  assign UNF         = unf_q;
  assign BUSY        = (state_q == BURST);
  assign FRAME_VALID = (state_q == BURST);
  assign FRAME_ADDR  = out_q - ONE;
  assign FRAME_IDX   = idx_q;
  assign FRAME_DONE  = done_q;
`ifdef STACK_SHADOW_EN
  assign SHADOW      = shadow_q;
`endif

endmodule

// File: tb/tb_stack_pointer_ctrl.sv
// Directed bench for stack_pointer_ctrl (WIDTH=8, RESET_VAL=0, DEPTH_MAX=255, FRAME_WORDS=2).
// Shadow-register steps are included when STACK_SHADOW_EN is defined.
module tb_stack_pointer_ctrl;

  logic       CLK = 1'b0;
  logic       RST, LD, INCR, DECR, FRAME_START, ERR_CLR;
  logic [7:0] DATA;
  logic [7:0] OUT, FRAME_ADDR;
  logic       EMPTY, FULL, OVF, UNF, BUSY, FRAME_VALID, FRAME_DONE;
  logic [1:0] FRAME_IDX;
`ifdef STACK_SHADOW_EN
  logic       SAVE, RESTORE;
  logic [7:0] SHADOW;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  stack_pointer_ctrl #(
    .WIDTH(8), .RESET_VAL(0), .DEPTH_MAX(255), .FRAME_WORDS(2)
  ) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .LD(LD), .INCR(INCR), .DECR(DECR),
    .FRAME_START(FRAME_START), .ERR_CLR(ERR_CLR),
`ifdef STACK_SHADOW_EN
    .SAVE(SAVE), .RESTORE(RESTORE), .SHADOW(SHADOW),
`endif
    .OUT(OUT), .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF), .UNF(UNF), .BUSY(BUSY),
    .FRAME_VALID(FRAME_VALID), .FRAME_ADDR(FRAME_ADDR), .FRAME_IDX(FRAME_IDX),
    .FRAME_DONE(FRAME_DONE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    RST = 0; LD = 0; INCR = 0; DECR = 0; FRAME_START = 0; ERR_CLR = 0; DATA = 8'h00;
`ifdef STACK_SHADOW_EN
    SAVE = 0; RESTORE = 0;
`endif
  endtask

  // Apply the currently driven inputs for one edge, then release them.
  task automatic step();
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #1;
    RST = 1; step();
    check("rst_out", OUT, 8'h00);
    check("rst_empty", EMPTY, 1);
    check("rst_full", FULL, 0);
    check("rst_ovf", OVF, 0);
    check("rst_unf", UNF, 0);
    check("rst_busy", BUSY, 0);
    check("rst_fvalid", FRAME_VALID, 0);
    check("rst_fidx", FRAME_IDX, 0);
    check("rst_fdone", FRAME_DONE, 0);
    check("rst_faddr", FRAME_ADDR, 8'hFF);

    INCR = 1; step();
    check("pop_empty_out", OUT, 8'h00);
    check("pop_empty_unf", UNF, 1);
    ERR_CLR = 1; step();
    check("errclr_unf", UNF, 0);

    DECR = 1; step();
    DECR = 1; step();
    DECR = 1; step();
    check("push3_out", OUT, 8'hFD);
    check("push3_empty", EMPTY, 0);
    INCR = 1; DECR = 1; step();
    check("incr_wins", OUT, 8'hFE);

    LD = 1; DATA = 8'h01; step();
    check("ld_out", OUT, 8'h01);
    check("ld_full", FULL, 1);
    check("ld_ovf_untouched", OVF, 0);
    DECR = 1; step();
    check("push_full_out", OUT, 8'h01);
    check("push_full_ovf", OVF, 1);
    DECR = 1; ERR_CLR = 1; step();
    check("set_beats_clr", OVF, 1);
    ERR_CLR = 1; step();
    check("ovf_clr", OVF, 0);

    LD = 1; DATA = 8'h20; step();
    FRAME_START = 1; step();
    check("f0_busy", BUSY, 1);
    check("f0_valid", FRAME_VALID, 1);
    check("f0_idx", FRAME_IDX, 0);
    check("f0_addr", FRAME_ADDR, 8'h1F);
    LD = 1; DATA = 8'h55; step();
    check("f1_idx", FRAME_IDX, 1);
    check("f1_addr", FRAME_ADDR, 8'h1E);
    check("f1_ld_ignored", OUT, 8'h1F);
    check("f1_done", FRAME_DONE, 0);
    step();
    check("fd_out", OUT, 8'h1E);
    check("fd_busy", BUSY, 0);
    check("fd_done", FRAME_DONE, 1);
    check("fd_idx", FRAME_IDX, 0);
    INCR = 1; step();
    check("fd_accept_incr", OUT, 8'h1F);
    check("fd_pulse_once", FRAME_DONE, 0);

    LD = 1; DATA = 8'h02; step();
    FRAME_START = 1; step();
    check("fovf_busy", BUSY, 0);
    check("fovf_ovf", OVF, 1);
    check("fovf_out", OUT, 8'h02);
    step();
    check("fovf_nodone", FRAME_DONE, 0);

    ERR_CLR = 1; LD = 1; DATA = 8'h03; step();
    FRAME_START = 1; step();
    check("fit_busy", BUSY, 1);
    check("fit_ovf", OVF, 0);
    step();
    check("fit_idx1", FRAME_IDX, 1);
    check("fit_out", OUT, 8'h02);
    RST = 1; step();
    check("rstb_out", OUT, 8'h00);
    check("rstb_busy", BUSY, 0);
    check("rstb_done", FRAME_DONE, 0);
    check("rstb_idx", FRAME_IDX, 0);
    step();
    check("rstb_nodone", FRAME_DONE, 0);

`ifdef STACK_SHADOW_EN
    check("sh_rst", SHADOW, 8'h00);
    LD = 1; DATA = 8'h40; step();
    SAVE = 1; step();
    check("sh_save", SHADOW, 8'h40);
    LD = 1; DATA = 8'h10; step();
    check("sh_ld", OUT, 8'h10);
    RESTORE = 1; LD = 1; DATA = 8'h77; step();
    check("sh_restore_out", OUT, 8'h40);
    check("sh_restore_sh", SHADOW, 8'h40);
    LD = 1; DATA = 8'h30; step();
    SAVE = 1; RESTORE = 1; step();
    check("sh_swap_out", OUT, 8'h40);
    check("sh_swap_sh", SHADOW, 8'h30);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
